// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and state
// encodings, default operand width and small op-decode helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_t;

    // Bit 1 selects divide, bit 0 selects the unsigned flavour.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_seq_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] exa;
    logic [WIDTH-1:0] exb;
    logic             hiwe;
    logic             lowe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, exa, exb, hiwe, lowe,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, exa, exb, hiwe, lowe,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: right shift-add for multiply, left shift-subtract
// (restoring) for divide, on a double-width {hi, lo} accumulator.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand};
        if (is_div) begin
            // Borrow out means the trial subtraction failed: keep the shifted remainder.
            if (diff[WIDTH]) begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; magnitudes are processed
// for WIDTH cycles, then signs are applied in a single fix-up cycle.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    mdu_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t         state;
    mdu_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               div_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (op_div),
        .acc_next (acc_next)
    );

    // Operand conditioning at request time; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        div_op = op_is_div(bus.op);
        sign_a = op_is_signed(bus.op) & bus.exa[WIDTH-1];
        sign_b = op_is_signed(bus.op) & bus.exb[WIDTH-1];
        abs_a  = sign_a ? neg_w(bus.exa) : bus.exa;
        abs_b  = sign_b ? neg_w(bus.exb) : bus.exb;
    end

    always_comb begin
        prod = neg_q ? neg_2w(acc) : acc;
        quo  = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem  = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        if (!op_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (cnt == '0) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != S_IDLE);
        bus.done = done;
        bus.hi   = hi;
        bus.lo   = lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            operand  <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_div   <= div_op;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= div_op && (bus.exb == '0);
                        a_raw    <= bus.exa;
                        cnt      <= CNT_W'(WIDTH-1);
                        // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
                        if (div_op) begin
                            acc     <= {{WIDTH{1'b0}}, abs_a};
                            operand <= abs_b;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, abs_b};
                            operand <= abs_a;
                        end
                    end else begin
                        if (bus.hiwe) hi <= bus.exa;
                        if (bus.lowe) lo <= bus.exa;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table, scoreboard of HI/LO results,
// and hand-written sequences for MTHI/MTLO, busy-time requests and reset abort.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[13];

    mdu_seq_if #(.WIDTH(W)) bus ();

    mdu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Every DONE pulse must match the oldest outstanding request.
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check("sb_hi", bus.hi, mon_e.hi);
                check("sb_lo", bus.lo, mon_e.lo);
            end
        end
    end

    task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit mid_start, input bit mid_write, input bit with_write);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int lat;
        int busy_cnt;
        int done0;
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.exa   = a;
        bus.exb   = b;
        bus.hiwe  = with_write;
        bus.lowe  = with_write;
        sb.push_back(exp_t'{eh, el});
        done0 = n_done;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hiwe  = 1'b0;
        bus.lowe  = 1'b0;
        busy_cnt  = int'(bus.busy);
        check($sformatf("v%0d_hi_hold_at_start", id), bus.hi, hi0);
        check($sformatf("v%0d_lo_hold_at_start", id), bus.lo, lo0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done === 1'b1) break;
            busy_cnt += int'(bus.busy);
            if (mid_start && lat == 5) begin
                bus.start = 1'b1;
                bus.op    = MDU_MULTU;
                bus.exa   = 32'd2;
                bus.exb   = 32'd3;
            end
            if (mid_write && lat == 5) begin
                hi0       = bus.hi;
                lo0       = bus.lo;
                bus.hiwe  = 1'b1;
                bus.lowe  = 1'b1;
                bus.exa   = 32'hDEADBEEF;
            end
            if (lat == 6) begin
                bus.start = 1'b0;
                bus.hiwe  = 1'b0;
                bus.lowe  = 1'b0;
                if (mid_write) begin
                    check($sformatf("v%0d_hi_busy_write", id), bus.hi, hi0);
                    check($sformatf("v%0d_lo_busy_write", id), bus.lo, lo0);
                end
            end
        end
        check($sformatf("v%0d_latency", id), 32'(lat), 32'(W + 1));
        check($sformatf("v%0d_busy_cycles", id), 32'(busy_cnt), 32'(W + 1));
        check($sformatf("v%0d_busy_low_at_done", id), 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_pulse", id), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_done_count", id), 32'(n_done - done0), 32'd1);
    endtask

    initial begin
        tbl = '{
            '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
            '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
            '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
            '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000},
            '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
            '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
            '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
            '{MDU_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF},
            '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
            '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF},
            '{MDU_MULTU, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF},
            '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003}
        };
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.exa   = '0;
        bus.exb   = '0;
        bus.hiwe  = 1'b0;
        bus.lowe  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0, 1'b0, 1'b0);
        end

        // Overflowing signed divide with a second request arriving while busy.
        run_op(20, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0);

        // MTHI/MTLO in idle.
        @(negedge clk);
        bus.hiwe = 1'b1;
        bus.lowe = 1'b1;
        bus.exa  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.hiwe = 1'b0;
        bus.lowe = 1'b0;
        check("mthi_mtlo_hi", bus.hi, 32'h12345678);
        check("mthi_mtlo_lo", bus.lo, 32'h12345678);
        @(negedge clk);
        bus.hiwe = 1'b1;
        bus.exa  = 32'hAAAA5555;
        @(posedge clk);
        #1;
        bus.hiwe = 1'b0;
        check("mthi_only_hi", bus.hi, 32'hAAAA5555);
        check("mthi_only_lo", bus.lo, 32'h12345678);

        // START together with HIWE/LOWE, then a write attempt while busy.
        run_op(21, MDU_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 1'b0, 1'b1);
        run_op(22, MDU_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_MULTU;
        bus.exa   = 32'hFFFFFFFF;
        bus.exb   = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(30, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);

        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
